pll_lock_ctrl: RTL



---
 rtl/pll_ctrl_pkg.sv | 21 ++
 rtl/sync_2ff.sv | 21 ++
 rtl/pll_lock_ctrl.sv | 115 +++++++++++
 3 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared state encoding and sizing helpers for the PLL lock supervisor.
package pll_ctrl_pkg;

    localparam int unsigned STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        RST_PLL   = 2'd0,
        WAIT_LOCK = 2'd1,
        STABLE    = 2'd2,
        RUN       = 2'd3
    } pll_state_t;

    // Largest of three cycle counts; sizes the shared state timer.
    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// 1-bit two-flop synchroniser with asynchronous active-high reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL supervisor: drives pll_reset, qualifies lock, retries on timeout or loss,
// and issues the system reset request plus saturating fault counters.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int unsigned PLL_RST_CYCLES = 16,
    parameter int unsigned LOCK_TIMEOUT   = 65536,
    parameter int unsigned STABLE_CYCLES  = 1024,
    parameter int unsigned CNT_W          = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               pll_lock,
    input  logic               restart,
    output logic               pll_reset,
    output logic               sys_reset,
    output logic               pll_ok,
    output logic [CNT_W-1:0]   timeout_count,
    output logic [CNT_W-1:0]   loss_count,
    output logic [STATE_W-1:0] state
);

    localparam int unsigned TIMER_W = $clog2(max3(PLL_RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [TIMER_W-1:0] RST_LAST    = TIMER_W'(PLL_RST_CYCLES - 1);
    localparam logic [TIMER_W-1:0] LOCK_LAST   = TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [TIMER_W-1:0] STABLE_LAST = TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX     = {CNT_W{1'b1}};

    pll_state_t         state_q;
    logic [TIMER_W-1:0] timer;
    logic               lock_s;

    sync_2ff u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (pll_lock),
        .q     (lock_s)
    );

    assign state = state_q;

    // Single registered FSM; restart overrides every state-specific decision.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= RST_PLL;
            timer         <= '0;
            pll_reset     <= 1'b1;
            sys_reset     <= 1'b1;
            pll_ok        <= 1'b0;
            timeout_count <= '0;
            loss_count    <= '0;
        end else if (restart) begin
            state_q   <= RST_PLL;
            timer     <= '0;
            pll_reset <= 1'b1;
            sys_reset <= 1'b1;
            pll_ok    <= 1'b0;
        end else begin
            timer <= timer + TIMER_W'(1);
            case (state_q)
                RST_PLL: begin
                    if (timer == RST_LAST) begin
                        state_q   <= WAIT_LOCK;
                        timer     <= '0;
                        pll_reset <= 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_q <= STABLE;
                        timer   <= '0;
                    end else if (timer == LOCK_LAST) begin
                        state_q   <= RST_PLL;
                        timer     <= '0;
                        pll_reset <= 1'b1;
                        if (timeout_count != CNT_MAX)
                            timeout_count <= timeout_count + CNT_W'(1);
                    end
                end
                STABLE: begin
                    if (!lock_s) begin
                        state_q <= WAIT_LOCK;
                        timer   <= '0;
                    end else if (timer == STABLE_LAST) begin
                        state_q   <= RUN;
                        timer     <= '0;
                        sys_reset <= 1'b0;
                        pll_ok    <= 1'b1;
                    end
                end
                RUN: begin
                    // Timer is idle here; parking it avoids needless toggling.
                    timer <= '0;
                    if (!lock_s) begin
                        state_q   <= RST_PLL;
                        pll_reset <= 1'b1;
                        sys_reset <= 1'b1;
                        pll_ok    <= 1'b0;
                        if (loss_count != CNT_MAX)
                            loss_count <= loss_count + CNT_W'(1);
                    end
                end
                default: begin
                    state_q   <= RST_PLL;
                    timer     <= '0;
                    pll_reset <= 1'b1;
                    sys_reset <= 1'b1;
                    pll_ok    <= 1'b0;
                end
            endcase
        end
    end

endmodule
